// File: rtl/counter_mode_sequencer.sv
// Command sequencer for the cascaded counter: accepts one command, loads D,
// runs the chosen mode for LEN cycles, counts RCO pulses and pulses DONE.
module counter_mode_sequencer #(
    parameter int WIDTH = 16,
    parameter int LEN_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [1:0]       CMD_MODO,
    input  logic [WIDTH-1:0] CMD_D,
    input  logic [LEN_W-1:0] CMD_LEN,
    output logic             ENB,
    output logic [1:0]       MODO,
    output logic [WIDTH-1:0] D,
    input  logic             RCO_IN,
    output logic [LEN_W-1:0] RCO_COUNT,
    output logic             BUSY,
    output logic             DONE
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [1:0]       mode_q, mode_nxt;
    logic [WIDTH-1:0] d_q, d_nxt;
    logic [LEN_W-1:0] rem_q, rem_nxt;
    logic [LEN_W-1:0] cnt_nxt;
    logic             ready_nxt, enb_nxt, busy_nxt, done_nxt;
    logic [1:0]       modo_nxt;
    logic [WIDTH-1:0] dout_nxt;
    logic             accept;

    assign accept = CMD_VALID && CMD_READY;

    always_comb begin
        state_nxt = state;
        mode_nxt  = mode_q;
        d_nxt     = d_q;
        rem_nxt   = rem_q;
        cnt_nxt   = RCO_COUNT;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    mode_nxt  = CMD_MODO;
                    d_nxt     = CMD_D;
                    rem_nxt   = CMD_LEN;
                    cnt_nxt   = '0;
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (mode_q == 2'b11 || rem_q == '0) state_nxt = S_DONE;
                else                                state_nxt = S_RUN;
            end
            S_RUN: begin
                // Saturate rather than wrap so a long run never under-reports.
                if (RCO_IN && RCO_COUNT != {LEN_W{1'b1}})
                    cnt_nxt = RCO_COUNT + LEN_W'(1);
                rem_nxt = rem_q - LEN_W'(1);
                if (rem_q == LEN_W'(1)) state_nxt = S_DONE;
            end
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they can be registered
        // and still line up with the state they belong to.
        ready_nxt = (state_nxt == S_IDLE);
        enb_nxt   = (state_nxt == S_LOAD) || (state_nxt == S_RUN);
        busy_nxt  = (state_nxt != S_IDLE);
        done_nxt  = (state_nxt == S_DONE);
        modo_nxt  = 2'b00;
        dout_nxt  = '0;
        if (state_nxt == S_LOAD) begin
            modo_nxt = 2'b11;
            dout_nxt = d_nxt;
        end else if (state_nxt == S_RUN) begin
            modo_nxt = mode_nxt;
            dout_nxt = d_nxt;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= S_IDLE;
            mode_q    <= 2'b00;
            d_q       <= '0;
            rem_q     <= '0;
            RCO_COUNT <= '0;
            CMD_READY <= 1'b1;
            ENB       <= 1'b0;
            MODO      <= 2'b00;
            D         <= '0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            state     <= state_nxt;
            mode_q    <= mode_nxt;
            d_q       <= d_nxt;
            rem_q     <= rem_nxt;
            RCO_COUNT <= cnt_nxt;
            CMD_READY <= ready_nxt;
            ENB       <= enb_nxt;
            MODO      <= modo_nxt;
            D         <= dout_nxt;
            BUSY      <= busy_nxt;
            DONE      <= done_nxt;
        end
    end

endmodule

// File: tb/tb_counter_mode_sequencer.sv
// Scoreboard bench: each issued command pushes its expected DONE cycle and
// RCO count; a monitor pops and compares on every DONE pulse.
module tb_counter_mode_sequencer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        CMD_VALID;
    logic        CMD_READY;
    logic [1:0]  CMD_MODO;
    logic [15:0] CMD_D;
    logic [7:0]  CMD_LEN;
    logic        ENB;
    logic [1:0]  MODO;
    logic [15:0] D;
    logic        RCO_IN;
    logic [7:0]  RCO_COUNT;
    logic        BUSY;
    logic        DONE;

    counter_mode_sequencer #(.WIDTH(16), .LEN_W(8)) dut (
        .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_MODO(CMD_MODO), .CMD_D(CMD_D), .CMD_LEN(CMD_LEN),
        .ENB(ENB), .MODO(MODO), .D(D), .RCO_IN(RCO_IN),
        .RCO_COUNT(RCO_COUNT), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int done_cyc;
        int rco;
    } exp_t;
    exp_t sb[$];

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every DONE pulse must match the oldest outstanding command.
    always @(negedge CLK) begin
        if (!RST && DONE) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_cycle", cyc, e.done_cyc);
                chk("done_rco_count", RCO_COUNT, e.rco);
            end
        end
    end

    // Called at a negedge; returns at the negedge of the LOAD cycle with
    // e0 = cycle index just before the handshake edge.
    task automatic issue(input logic [1:0] m, input logic [15:0] d, input logic [7:0] len,
                         input int exp_rco, input bit expect_done, input bit hold,
                         output int e0);
        exp_t e;
        int n;
        CMD_VALID = 1'b1;
        CMD_MODO  = m;
        CMD_D     = d;
        CMD_LEN   = len;
        n = 0;
        while (!CMD_READY && n < 400) begin
            @(negedge CLK);
            n++;
        end
        chk("ready_wait", CMD_READY, 1);
        e0 = cyc;
        if (expect_done) begin
            e.done_cyc = (m == 2'b11 || len == 8'd0) ? e0 + 2 : e0 + int'(len) + 2;
            e.rco      = exp_rco;
            sb.push_back(e);
        end
        @(negedge CLK);
        if (!hold) CMD_VALID = 1'b0;
    endtask

    initial begin
        int e0, ea, eb;
        RST = 1'b1; CMD_VALID = 1'b0; CMD_MODO = 2'b00; CMD_D = '0; CMD_LEN = '0; RCO_IN = 1'b0;

        // Reset values appear before any clock edge.
        #1;
        chk("rst_ready", CMD_READY, 1);
        chk("rst_enb", ENB, 0);
        chk("rst_modo", MODO, 0);
        chk("rst_d", D, 0);
        chk("rst_rco", RCO_COUNT, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk("post_rst_ready", CMD_READY, 1);

        // Up count with RCO pulses in RUN 2 and 3; pulses in LOAD/DONE ignored.
        issue(2'b00, 16'h00FE, 8'd4, 2, 1, 0, e0);
        chk("load_enb", ENB, 1);
        chk("load_modo", MODO, 3);
        chk("load_d", D, 16'h00FE);
        chk("load_ready", CMD_READY, 0);
        chk("load_busy", BUSY, 1);
        RCO_IN = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge CLK);
            chk("run_enb", ENB, 1);
            chk("run_modo", MODO, 0);
            chk("run_d", D, 16'h00FE);
            RCO_IN = (k == 2 || k == 3);
        end
        @(negedge CLK);
        chk("done_enb", ENB, 0);
        chk("done_modo", MODO, 0);
        chk("done_ready", CMD_READY, 0);
        RCO_IN = 1'b1;
        @(negedge CLK);
        chk("idle_ready", CMD_READY, 1);
        chk("idle_rco_hold", RCO_COUNT, 2);
        chk("idle_busy", BUSY, 0);
        RCO_IN = 1'b0;

        // Load only: LEN ignored, no RUN.
        issue(2'b11, 16'hA5A5, 8'd9, 0, 1, 0, e0);
        chk("lo_load_d", D, 16'hA5A5);
        chk("lo_load_modo", MODO, 3);
        RCO_IN = 1'b1;
        @(negedge CLK);
        chk("lo_done_enb", ENB, 0);
        RCO_IN = 1'b0;
        @(negedge CLK);
        chk("lo_idle_ready", CMD_READY, 1);

        // Back-to-back with VALID held and RCO tied high: A counts 2, B counts 3.
        RCO_IN = 1'b1;
        issue(2'b00, 16'h1111, 8'd2, 2, 1, 1, ea);
        CMD_MODO = 2'b01; CMD_LEN = 8'd3;
        issue(2'b01, 16'h2222, 8'd3, 3, 1, 0, eb);
        chk("b2b_gap", eb - ea, 5);
        chk("b2b_load_d", D, 16'h2222);
        @(negedge CLK);
        chk("b2b_run_modo", MODO, 1);
        repeat (4) @(negedge CLK);
        chk("b2b_idle_ready", CMD_READY, 1);
        RCO_IN = 1'b0;

        // Saturation: 255 RUN cycles with RCO high.
        RCO_IN = 1'b1;
        issue(2'b00, 16'h1234, 8'd255, 255, 1, 0, e0);
        repeat (256) @(negedge CLK);
        @(negedge CLK);
        chk("sat_hold", RCO_COUNT, 255);
        RCO_IN = 1'b0;

        // Asynchronous reset in the 3rd RUN cycle: no DONE, count cleared.
        RCO_IN = 1'b1;
        issue(2'b01, 16'h0100, 8'd10, 0, 0, 0, e0);
        repeat (3) @(negedge CLK);
        chk("mid_run_enb", ENB, 1);
        chk("mid_run_rco", RCO_COUNT, 2);
        #2 RST = 1'b1;
        #1;
        chk("abort_enb", ENB, 0);
        chk("abort_busy", BUSY, 0);
        chk("abort_ready", CMD_READY, 1);
        chk("abort_rco", RCO_COUNT, 0);
        chk("abort_done", DONE, 0);
        RCO_IN = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        issue(2'b10, 16'h0009, 8'd1, 0, 1, 0, e0);
        chk("after_abort_rco", RCO_COUNT, 0);
        chk("after_abort_load_modo", MODO, 3);
        @(negedge CLK);
        chk("after_abort_run_modo", MODO, 2);
        repeat (2) @(negedge CLK);
        chk("after_abort_ready", CMD_READY, 1);

        repeat (3) @(negedge CLK);
        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
